rr_arb8_ctrl: RTL and testbench

RR_ARB8_CTRL -- requirements
Module: rr_arb8_ctrl

---
 rtl/arb_pkg.sv | 17 +
 rtl/prio_enc8.sv | 19 +
 rtl/rr_arb8_ctrl.sv | 118 +++++++++++
 tb/tb_rr_arb8_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and grant decode helper for the
// 8-way round-robin arbiter.
package arb_pkg;

    localparam int NREQ = 8;
    localparam int IDW  = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] id_to_onehot(input logic [IDW-1:0] id);
        return 8'd1 << id;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the lowest set index wins.
module prio_enc8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    output logic [IDW-1:0]  o_idx,
    output logic            o_valid
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = 3'd0;
        o_valid = |i_req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            o_idx = i_req[i] ? 3'(i) : o_idx;
        end
    end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter sharing one resource among eight requesters, with a
// bounded hold time and a one-cycle timeout pulse when a grant is revoked.
module rr_arb8_ctrl
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [7:0]      r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_gnt_id;
    logic            r_gnt_valid;
    logic            r_timeout;

    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_req_masked;
    logic [IDW-1:0]  w_m_idx;
    logic            w_m_valid;
    logic [IDW-1:0]  w_u_idx;
    logic            w_u_valid;
    logic [IDW-1:0]  w_sel_id;
    logic            w_release;
    logic            w_expire;

    // Requesters at or above the pointer get first pick; otherwise wrap to 0.
    assign w_mask       = 8'hFF << r_ptr;
    assign w_req_masked = req & w_mask;

    prio_enc8 u_enc_masked (
        .i_req   (w_req_masked),
        .o_idx   (w_m_idx),
        .o_valid (w_m_valid)
    );

    prio_enc8 u_enc_unmasked (
        .i_req   (req),
        .o_idx   (w_u_idx),
        .o_valid (w_u_valid)
    );

    assign w_sel_id  = w_m_valid ? w_m_idx : w_u_idx;
    assign w_release = done | ~req[r_gnt_id];
    assign w_expire  = (r_cnt == CNT_LAST);

    // Arbitration FSM with registered grant outputs and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= 3'd0;
            r_cnt       <= 8'd0;
            r_gnt       <= 8'd0;
            r_gnt_id    <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    r_cnt     <= 8'd0;
                    if (w_u_valid) begin
                        r_state     <= GRANT;
                        r_gnt       <= id_to_onehot(w_sel_id);
                        r_gnt_id    <= w_sel_id;
                        r_gnt_valid <= 1'b1;
                    end else begin
                        r_state     <= IDLE;
                        r_gnt       <= 8'd0;
                        r_gnt_id    <= 3'd0;
                        r_gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    // A release on the final counter cycle wins over the timeout.
                    if (w_release || w_expire) begin
                        r_state     <= IDLE;
                        r_ptr       <= r_gnt_id + 3'd1;
                        r_cnt       <= 8'd0;
                        r_gnt       <= 8'd0;
                        r_gnt_id    <= 3'd0;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= ~w_release;
                    end else begin
                        r_cnt     <= r_cnt + 8'd1;
                        r_timeout <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_ptr       <= 3'd0;
                    r_cnt       <= 8'd0;
                    r_gnt       <= 8'd0;
                    r_gnt_id    <= 3'd0;
                    r_gnt_valid <= 1'b0;
                    r_timeout   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against a behavioural round-robin model.
module tb_rr_arb8_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    rr_arb8_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] e_gnt;
        logic [2:0] e_id;
        logic       e_v;
        logic       e_to;
    } vec_t;

    vec_t vecs [24];

    // Behavioural model: holder index (-1 = none), pointer, hold count.
    int m_hold, m_ptr, m_cnt;
    bit m_to;

    task automatic model_step(input logic r, input logic [7:0] rq, input logic d);
        if (r) begin
            m_hold = -1; m_ptr = 0; m_cnt = 0; m_to = 0;
        end else if (m_hold < 0) begin
            m_to = 0;
            for (int k = 0; k < 8; k++) begin
                if (m_hold < 0 && rq[(m_ptr + k) % 8]) m_hold = (m_ptr + k) % 8;
            end
            m_cnt = 0;
        end else if (d || !rq[m_hold]) begin
            m_ptr = (m_hold + 1) % 8; m_hold = -1; m_to = 0;
        end else if (m_cnt == TO - 1) begin
            m_ptr = (m_hold + 1) % 8; m_hold = -1; m_to = 1;
        end else begin
            m_cnt++; m_to = 0;
        end
    endtask

    task automatic cycle(input logic r, input logic [7:0] rq, input logic d);
        rst = r; req = rq; done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int step, input logic [7:0] eg,
                         input logic [2:0] eid, input logic ev, input logic eto);
        n_checks++;
        if ({gnt, gnt_id, gnt_valid, timeout} !== {eg, eid, ev, eto}) begin
            n_errors++;
            $display("FAIL %s step %0d: got gnt=%h id=%0d v=%0b to=%0b, expected gnt=%h id=%0d v=%0b to=%0b",
                     nm, step, gnt, gnt_id, gnt_valid, timeout, eg, eid, ev, eto);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h01, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h05, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'hFF, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'h80, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 24; i++) begin
            cycle(vecs[i].rst, vecs[i].req, vecs[i].done);
            check("table", i, vecs[i].e_gnt, vecs[i].e_id, vecs[i].e_v, vecs[i].e_to);
        end

        // All requesting, done once per grant: ids 0..7 then 0, idle between.
        cycle(1'b1, 8'h00, 1'b0);
        for (int g = 0; g < 9; g++) begin
            cycle(1'b0, 8'hFF, 1'b0);
            check("rr_seq_grant", g, 8'd1 << (g % 8), 3'(g % 8), 1'b1, 1'b0);
            cycle(1'b0, 8'hFF, 1'b1);
            check("rr_seq_idle", g, 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Reset in the middle of a grant to requester 5.
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'h20, 1'b0);
        check("rst_mid_pre", 0, 8'h20, 3'd5, 1'b1, 1'b0);
        cycle(1'b0, 8'h20, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        check("rst_mid_drop", 1, 8'h00, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 8'hFF, 1'b0);
        check("rst_mid_first", 2, 8'h01, 3'd0, 1'b1, 1'b0);

        // Holder drops its request bit.
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'h30, 1'b0);
        check("drop_grant", 0, 8'h10, 3'd4, 1'b1, 1'b0);
        cycle(1'b0, 8'h20, 1'b0);
        check("drop_release", 1, 8'h00, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 8'h20, 1'b0);
        check("drop_next", 2, 8'h20, 3'd5, 1'b1, 1'b0);

        // Randomized run against the model.
        cycle(1'b1, 8'h00, 1'b0);
        model_step(1'b1, 8'h00, 1'b0);
        for (int t = 0; t < 600; t++) begin
            logic       r_r;
            logic [7:0] r_q;
            logic       r_d;
            r_r = ($urandom_range(0, 59) == 0);
            r_q = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0 && m_hold >= 0) r_q[m_hold] = 1'b1;
            r_d = ($urandom_range(0, 5) == 0);
            cycle(r_r, r_q, r_d);
            model_step(r_r, r_q, r_d);
            check("random", t, (m_hold >= 0) ? (8'd1 << m_hold) : 8'h00,
                  (m_hold >= 0) ? 3'(m_hold) : 3'd0, m_hold >= 0, m_to);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
